// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI-lite read-channel arbiter (m0 = IFU fetch, m1 = LSU load).
// One transaction in flight; round-robin or fixed m1 priority on a tie.
module axi_rd_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter bit          FIX_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rresp,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    input  logic [AW-1:0] m1_araddr,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rresp,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [AW-1:0] s_araddr,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rresp,
    input  logic          s_rvalid,
    output logic          s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          gnt_r;
    logic          last_r;
    logic [AW-1:0] addr_r;
    logic          s_arvalid_r;
    logic          run_r;
    logic          sel_s;
    logic          accept_s;
    logic          r_hs_s;
    logic          rready_s;

    assign s_araddr  = addr_r;
    assign s_arvalid = s_arvalid_r;
    assign s_rready  = rready_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, last-served, latched address, slave AR valid and the out-of-reset qualifier.
    // run_r keeps arready low while reset is held even though state_r is already IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r       <= 1'b0;
            last_r      <= 1'b1;
            addr_r      <= {AW{1'b0}};
            s_arvalid_r <= 1'b0;
            run_r       <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (accept_s) begin
                gnt_r       <= sel_s;
                addr_r      <= sel_s ? m1_araddr : m0_araddr;
                s_arvalid_r <= 1'b1;
            end else if (s_arvalid_r && s_arready) begin
                s_arvalid_r <= 1'b0;
            end
            if (r_hs_s) begin
                last_r <= gnt_r;
            end
        end
    end

    // Next-state, arbitration and master-side response steering.
    always_comb begin
        state_s    = state_r;
        sel_s      = 1'b0;
        accept_s   = 1'b0;
        r_hs_s     = 1'b0;
        rready_s   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = {DW{1'b0}};
        m0_rresp   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = {DW{1'b0}};
        m1_rresp   = 1'b0;
        case (state_r)
            IDLE: begin
                if (m0_arvalid && m1_arvalid) begin
                    sel_s = FIX_PRIO ? 1'b1 : ~last_r;
                end else if (m1_arvalid) begin
                    sel_s = 1'b1;
                end else begin
                    sel_s = 1'b0;
                end
                if (run_r && (m0_arvalid || m1_arvalid)) begin
                    accept_s   = 1'b1;
                    m0_arready = ~sel_s;
                    m1_arready = sel_s;
                    state_s    = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_s = DATA;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                rready_s = gnt_r ? m1_rready : m0_rready;
                if (gnt_r) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                if (s_rvalid && rready_s) begin
                    r_hs_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin and a fixed-priority instance share master
// stimulus; each has its own SRAM responder returning addr + 32'h8000_0413.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic        arready_en, resp_val;

    logic        a_m0_arready, a_m0_rresp, a_m0_rvalid, a_m1_arready, a_m1_rresp, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_araddr, a_s_rdata;
    logic        a_s_arvalid, a_s_rvalid, a_s_rready;
    logic        b_m0_arready, b_m0_rresp, b_m0_rvalid, b_m1_arready, b_m1_rresp, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_araddr, b_s_rdata;
    logic        b_s_arvalid, b_s_rvalid, b_s_rready;

    logic        pend_a, pend_b;
    logic [31:0] pdata_a, pdata_b;
    int          q_a[$];
    int          q_b[$];
    int          rh_a = 0;
    int          rh_b = 0;
    int          checks = 0;
    int          failures = 0;
    logic        any_a, any_b;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.AW(32), .DW(32), .FIX_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(a_m0_arready),
        .m0_rdata(a_m0_rdata), .m0_rresp(a_m0_rresp), .m0_rvalid(a_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(a_m1_arready),
        .m1_rdata(a_m1_rdata), .m1_rresp(a_m1_rresp), .m1_rvalid(a_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(arready_en),
        .s_rdata(a_s_rdata), .s_rresp(resp_val), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready)
    );

    axi_rd_arbiter #(.AW(32), .DW(32), .FIX_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
        .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
        .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(arready_en),
        .s_rdata(b_s_rdata), .s_rresp(resp_val), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready)
    );

    // SRAM responders: one read per accepted address, reset by the same rst.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_a <= 1'b0; pdata_a <= 32'h0;
            pend_b <= 1'b0; pdata_b <= 32'h0;
        end else begin
            if (a_s_arvalid && arready_en) begin
                pend_a <= 1'b1; pdata_a <= a_s_araddr + 32'h8000_0413;
            end else if (pend_a && a_s_rready) begin
                pend_a <= 1'b0;
            end
            if (b_s_arvalid && arready_en) begin
                pend_b <= 1'b1; pdata_b <= b_s_araddr + 32'h8000_0413;
            end else if (pend_b && b_s_rready) begin
                pend_b <= 1'b0;
            end
        end
    end
    assign a_s_rvalid = pend_a;
    assign a_s_rdata  = pdata_a;
    assign b_s_rvalid = pend_b;
    assign b_s_rdata  = pdata_b;

    // Grant log (0 = m0, 1 = m1) and R-handshake counters.
    always @(posedge clk) begin
        if (m0_arvalid && a_m0_arready) q_a.push_back(0);
        if (m1_arvalid && a_m1_arready) q_a.push_back(1);
        if (m0_arvalid && b_m0_arready) q_b.push_back(0);
        if (m1_arvalid && b_m1_arready) q_b.push_back(1);
        if (a_s_rvalid && a_s_rready) rh_a <= rh_a + 1;
        if (b_s_rvalid && b_s_rready) rh_b <= rh_b + 1;
    end

    assign any_a = a_m0_arready | a_m0_rresp | a_m0_rvalid | (|a_m0_rdata) | a_m1_arready | a_m1_rresp |
                   a_m1_rvalid | (|a_m1_rdata) | a_s_arvalid | (|a_s_araddr) | a_s_rready;
    assign any_b = b_m0_arready | b_m0_rresp | b_m0_rvalid | (|b_m0_rdata) | b_m1_arready | b_m1_rresp |
                   b_m1_rvalid | (|b_m1_rdata) | b_s_arvalid | (|b_s_araddr) | b_s_rready;

    task automatic test_reset();
        rst = 1'b0; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_araddr = 32'h0; m1_araddr = 32'h0; m0_rready = 1'b1; m1_rready = 1'b1;
        arready_en = 1'b1; resp_val = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (any_a !== 1'b0) begin failures++; $display("FAIL reset_zero_rr: any output=%b expected 0", any_a); end
        checks++;
        if (any_b !== 1'b0) begin failures++; $display("FAIL reset_zero_fp: any output=%b expected 0", any_b); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({a_m0_arready, a_m1_arready} !== 2'b10) begin
            failures++; $display("FAIL reset_first_grant_rr: arready m0,m1=%b expected 10", {a_m0_arready, a_m1_arready});
        end
        checks++;
        if ({b_m0_arready, b_m1_arready} !== 2'b01) begin
            failures++; $display("FAIL reset_first_grant_fp: arready m0,m1=%b expected 01", {b_m0_arready, b_m1_arready});
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    endtask

    task automatic test_single_m0();
        int rh0;
        @(negedge clk);
        rh0 = rh_a;
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; resp_val = 1'b1;
        #1;
        checks++;
        if ({a_m0_arready, a_m1_arready} !== 2'b10) begin
            failures++; $display("FAIL single_arready: m0,m1=%b expected 10", {a_m0_arready, a_m1_arready});
        end
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        checks++;
        if (a_m0_arready !== 1'b0 || a_s_arvalid !== 1'b1 || a_s_araddr !== 32'h8000_0000) begin
            failures++; $display("FAIL single_addr: arready=%b s_arvalid=%b s_araddr=%h expected 0 1 80000000",
                                 a_m0_arready, a_s_arvalid, a_s_araddr);
        end
        @(negedge clk); #1;
        checks++;
        if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'h0000_0413 || a_m0_rresp !== 1'b1) begin
            failures++; $display("FAIL single_data: rvalid=%b rdata=%h rresp=%b expected 1 00000413 1",
                                 a_m0_rvalid, a_m0_rdata, a_m0_rresp);
        end
        checks++;
        if (a_m1_rvalid !== 1'b0 || a_m1_rdata !== 32'h0 || a_m1_rresp !== 1'b0) begin
            failures++; $display("FAIL single_m1_quiet: rvalid=%b rdata=%h rresp=%b expected 0 0 0",
                                 a_m1_rvalid, a_m1_rdata, a_m1_rresp);
        end
        @(negedge clk); #1;
        checks++;
        if (a_m0_rvalid !== 1'b0 || a_s_arvalid !== 1'b0 || rh_a !== rh0 + 1) begin
            failures++; $display("FAIL single_done: rvalid=%b s_arvalid=%b handshakes=%0d expected 0 0 %0d",
                                 a_m0_rvalid, a_s_arvalid, rh_a - rh0, 1);
        end
        resp_val = 1'b0;
    endtask

    task automatic test_round_robin();
        int rh0;
        int got;
        @(negedge clk);
        q_a.delete(); q_b.delete();
        rh0 = rh_a;
        m0_araddr = 32'h0000_0100; m1_araddr = 32'h0000_0200;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int n = 0; n < 100 && q_a.size() < 8; n++) @(negedge clk);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        checks++;
        if (q_a.size() !== 8) begin failures++; $display("FAIL rr_count: grants=%0d expected 8", q_a.size()); end
        // m0 was served last, so the first tie goes to m1.
        for (int i = 0; i < 8; i++) begin
            got = (i < q_a.size()) ? q_a[i] : -1;
            checks++;
            if (got !== ((i % 2 == 0) ? 1 : 0)) begin
                failures++; $display("FAIL rr_order[%0d]: grant=%0d expected %0d", i, got, (i % 2 == 0) ? 1 : 0);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rh_a - rh0 !== 8) begin failures++; $display("FAIL rr_handshakes: count=%0d expected 8", rh_a - rh0); end
    endtask

    task automatic test_fix_prio();
        int got;
        @(negedge clk);
        q_b.delete();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int n = 0; n < 100 && q_b.size() < 4; n++) @(negedge clk);
        m1_arvalid = 1'b0;
        for (int n = 0; n < 50 && q_b.size() < 5; n++) @(negedge clk);
        m0_arvalid = 1'b0;
        checks++;
        if (q_b.size() !== 5) begin failures++; $display("FAIL fp_count: grants=%0d expected 5", q_b.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < q_b.size()) ? q_b[i] : -1;
            checks++;
            if (got !== ((i < 4) ? 1 : 0)) begin
                failures++; $display("FAIL fp_order[%0d]: grant=%0d expected %0d", i, got, (i < 4) ? 1 : 0);
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int rh0;
        @(negedge clk);
        rh0 = rh_a;
        arready_en = 1'b0; m1_rready = 1'b0;
        m1_araddr = 32'h0000_1234; m1_arvalid = 1'b1;
        @(negedge clk);
        m1_arvalid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            checks++;
            if (a_s_arvalid !== 1'b1 || a_s_araddr !== 32'h0000_1234) begin
                failures++; $display("FAIL bp_addr_hold[%0d]: s_arvalid=%b s_araddr=%h expected 1 00001234",
                                     k, a_s_arvalid, a_s_araddr);
            end
            @(negedge clk);
        end
        arready_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'h8000_1647 || a_s_rready !== 1'b0 || a_s_arvalid !== 1'b0) begin
                failures++; $display("FAIL bp_data_hold[%0d]: rvalid=%b rdata=%h s_rready=%b s_arvalid=%b expected 1 80001647 0 0",
                                     k, a_m1_rvalid, a_m1_rdata, a_s_rready, a_s_arvalid);
            end
            @(negedge clk);
        end
        m1_rready = 1'b1;
        #1;
        checks++;
        if (a_s_rready !== 1'b1) begin failures++; $display("FAIL bp_rready: s_rready=%b expected 1", a_s_rready); end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (rh_a - rh0 !== 1 || a_m1_rvalid !== 1'b0) begin
            failures++; $display("FAIL bp_one_handshake: count=%0d rvalid=%b expected 1 0", rh_a - rh0, a_m1_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        int rh0;
        @(negedge clk);
        m1_araddr = 32'h0000_0040; m1_arvalid = 1'b1; m1_rready = 1'b0;
        @(negedge clk);
        m1_arvalid = 1'b0;
        @(negedge clk);
        m0_arvalid = 1'b1;
        #1;
        checks++;
        if (a_m1_rvalid !== 1'b1 || a_m0_arready !== 1'b0) begin
            failures++; $display("FAIL mid_in_data: m1_rvalid=%b m0_arready=%b expected 1 0", a_m1_rvalid, a_m0_arready);
        end
        rh0 = rh_a;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (any_a !== 1'b0 || any_b !== 1'b0) begin
            failures++; $display("FAIL mid_reset_zero: any rr=%b fp=%b expected 0 0", any_a, any_b);
        end
        m0_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; m1_rready = 1'b1; m1_araddr = 32'h0000_0080; m1_arvalid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (a_m1_arready !== 1'b1) begin failures++; $display("FAIL mid_rearm: m1_arready=%b expected 1", a_m1_arready); end
        @(negedge clk);
        m1_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 32'h8000_0493) begin
            failures++; $display("FAIL mid_new_read: rvalid=%b rdata=%h expected 1 80000493", a_m1_rvalid, a_m1_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rh_a - rh0 !== 1) begin failures++; $display("FAIL mid_handshakes: count=%0d expected 1", rh_a - rh0); end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_round_robin();
        test_fix_prio();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
